// File: rtl/sevenseg_mux_decoder.sv
// rtl/sevenseg_mux_decoder.sv - two-digit multiplexed 7-segment bus monitor
// Deglitches each digit, decodes to hex and publishes coherent two-digit frames.
module sevenseg_mux_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg,
  input  logic [1:0] com,
  input  logic [1:0] com_oe,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] dp,
  output logic [1:0] blank,
  output logic       frame_valid,
  output logic       display_ok,
  output logic       glyph_err,
  output logic       overlap_err
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_TEN, CLS_BOTH} cls_t;
  typedef enum logic [1:0] {EMPTY, HAVE_ONE, HAVE_TEN} state_t;

  // Returns {bad, nibble}; all-dark is handled separately as blank.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      7'h00: decode = 5'h00;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [7:0]    lit;
  logic [1:0]    act;
  cls_t          cls;
  logic          digit;
  logic          same;
  logic [4:0]    dec;
  logic          accept;
  logic          complete;
  logic [SW-1:0] cnt_next;

  cls_t          prev_cls;
  logic [7:0]    prev_lit;
  logic [SW-1:0] cnt;
  state_t        state, state_next;
  logic          complete_q;
  logic [TW-1:0] tcnt;

  logic [3:0] ones_sh, tens_sh;
  logic       ones_dp, tens_dp, ones_blank, tens_blank, ones_bad, tens_bad;

  always_comb begin
    lit   = seg_pol ? seg : ~seg;
    act   = {com[1] == com_pol, com[0] == com_pol} & com_oe;
    cls   = cls_t'(act);
    digit = (cls == CLS_ONE) || (cls == CLS_TEN);
    same  = (cls == prev_cls) && (lit == prev_lit);
    dec   = decode(lit[6:0]);
    if (!digit)
      cnt_next = '0;
    else if (!same)
      cnt_next = S_ONE;
    else if (cnt == S_MAX)
      cnt_next = cnt;
    else
      cnt_next = cnt + S_ONE;
    // Saturated-and-unchanged means this glyph was already accepted.
    accept = digit && (cnt_next == S_MAX) && !(same && (cnt == S_MAX));
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    if (accept) begin
      case (state)
        EMPTY:    state_next = (cls == CLS_ONE) ? HAVE_ONE : HAVE_TEN;
        HAVE_ONE: if (cls == CLS_TEN) begin
                    complete   = 1'b1;
                    state_next = EMPTY;
                  end
        HAVE_TEN: if (cls == CLS_ONE) begin
                    complete   = 1'b1;
                    state_next = EMPTY;
                  end
        default:  state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cls    <= CLS_NONE;
      prev_lit    <= '0;
      cnt         <= '0;
      state       <= EMPTY;
      complete_q  <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      prev_cls    <= cls;
      prev_lit    <= lit;
      cnt         <= cnt_next;
      state       <= state_next;
      complete_q  <= complete;
      overlap_err <= (cls == CLS_BOTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_sh    <= '0;
      tens_sh    <= '0;
      ones_dp    <= 1'b0;
      tens_dp    <= 1'b0;
      ones_blank <= 1'b0;
      tens_blank <= 1'b0;
      ones_bad   <= 1'b0;
      tens_bad   <= 1'b0;
    end else if (accept) begin
      if (cls == CLS_ONE) begin
        ones_sh    <= dec[3:0];
        ones_bad   <= dec[4];
        ones_dp    <= lit[7];
        ones_blank <= (lit[6:0] == 7'h00);
      end else begin
        tens_sh    <= dec[3:0];
        tens_bad   <= dec[4];
        tens_dp    <= lit[7];
        tens_blank <= (lit[6:0] == 7'h00);
      end
    end
  end

  // Published frame and liveness timer; outputs hold across a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones        <= '0;
      tens        <= '0;
      dp          <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
      display_ok  <= 1'b0;
      tcnt        <= '0;
    end else if (complete_q) begin
      ones        <= ones_sh;
      tens        <= tens_sh;
      dp          <= {tens_dp, ones_dp};
      blank       <= {tens_blank, ones_blank};
      frame_valid <= 1'b1;
      glyph_err   <= ones_bad | tens_bad;
      display_ok  <= 1'b1;
      tcnt        <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (tcnt != T_MAX)
        tcnt <= tcnt + TW'(1);
      if (tcnt == T_LAST)
        display_ok <= 1'b0;
    end
  end

endmodule
